// File: rtl/data_ram_ctrl.sv
// Single-port data RAM with byte write masks, 1-cycle registered reads,
// out-of-range detection and a sequential clear engine that also initialises the array.
module data_ram_ctrl #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  enable_read,
  input  logic                  enable_write,
  input  logic [DATA_W/8-1:0]   wmask,
  input  logic [DATA_W-1:0]     DMin,
  input  logic                  clear,
  output logic [DATA_W-1:0]     DMout,
  output logic                  rvalid,
  output logic                  busy,
  output logic                  oob
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST    = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    CLEAR
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      ptr;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic                  accept;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [NBYTES-1:0]     mem_be;
  logic [DATA_W-1:0]     mem_wdata;

  assign in_range = ({1'b0, address} < DEPTH_L);
  assign idx      = address[IDX_W-1:0];
  assign accept   = (state == IDLE) && !clear;

  // The clear engine owns the array port while busy; otherwise only in-range accepted writes reach it.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = idx;
    mem_be    = wmask;
    mem_wdata = DMin;
    if (state == INIT || state == CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = ptr;
      mem_be    = '1;
      mem_wdata = '0;
    end else if (accept && enable_write && in_range) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (mem_be[k]) mem[mem_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= INIT;
      ptr    <= '0;
      busy   <= 1'b1;
      DMout  <= '0;
      rvalid <= 1'b0;
      oob    <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      oob    <= 1'b0;
      case (state)
        INIT, CLEAR: begin
          if (ptr == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            ptr   <= '0;
          end else begin
            ptr   <= ptr + IDX_W'(1);
          end
        end
        IDLE: begin
          if (clear) begin
            state <= CLEAR;
            busy  <= 1'b1;
            ptr   <= '0;
          end else begin
            // Read-first: mem still holds the pre-write word at this edge.
            if (enable_read) begin
              rvalid <= 1'b1;
              DMout  <= in_range ? mem[idx] : '0;
            end
            if ((enable_read || enable_write) && !in_range) oob <= 1'b1;
          end
        end
        default: begin
          state <= INIT;
          busy  <= 1'b1;
          ptr   <= '0;
        end
      endcase
    end
  end

endmodule
